sar_ctrl_10b: RTL

- Successive-approximation sequencer for the 10-bit ADC datapath.
- Drives the sample/hold `sample` strobe, then runs a binary search on the DAC trial code using the comparator decision.
- Returns the converted word with a one-cycle `done` pulse.
- Sits between the top-level ADC FSM wrapper and the samplehold/DAC/comparator datapath.

---
 rtl/sar_ctrl_10b.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/sar_ctrl_10b.sv
// Successive-approximation sequencer: samples the input, then binary-searches the
// DAC trial code using the comparator decision and returns the word with a done pulse.
module sar_ctrl_10b #(
    parameter int NBITS         = 10,
    parameter int SAMPLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp_in,
    output logic             sample,
    output logic [NBITS-1:0] dac_code,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] dout
);

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        HOLD,
        CONV,
        DONE
    } state_t;

    localparam logic [7:0]       CNT_LOAD = 8'(SAMPLE_CYCLES - 1);
    localparam logic [3:0]       K_TOP    = 4'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_ONLY = {1'b1, {(NBITS-1){1'b0}}};

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [3:0]       k_q, k_d;
    logic [NBITS-1:0] dac_q, dac_d;
    logic [NBITS-1:0] dout_q, dout_d;
    logic             sample_q, sample_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Every output is computed one state ahead so that all of them come straight from flops.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        sample_d = 1'b0;
        busy_d   = 1'b1;
        done_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start && !abort) begin
                    state_d  = SAMPLE;
                    sample_d = 1'b1;
                    cnt_d    = CNT_LOAD;
                    dac_d    = '0;
                end else begin
                    state_d = IDLE;
                    dac_d   = '0;
                    busy_d  = 1'b0;
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    dac_d   = '0;
                    busy_d  = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    sample_d = 1'b1;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d = IDLE;
                    dac_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    state_d = CONV;
                    dac_d   = MSB_ONLY;
                    k_d     = K_TOP;
                end
            end
            CONV: begin
                if (abort) begin
                    state_d = IDLE;
                    dac_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    // Keep or drop the bit under trial, then offer the next lower bit.
                    dac_d[k_q] = cmp_in;
                    if (k_q != 4'd0) begin
                        dac_d[k_q - 4'd1] = 1'b1;
                        k_d               = k_q - 4'd1;
                    end else begin
                        dout_d  = dac_d;
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                dac_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            dac_q    <= '0;
            dout_q   <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            sample_q <= sample_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign sample   = sample_q;
    assign dac_code = dac_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign dout     = dout_q;

endmodule
